// File: rtl/btb_ctrl.sv
// btb_ctrl: sequencing controller for the 4-way BTB/BHT datapath.
// Turns resolve-stage outcomes into allocate writes (WRITE -> CLEAR) and BHT
// updates, issues LRU touches for IF-stage hits and runs a set-by-set flush.
// Optional statistics counters are built when the macro BTB_STATS_EN is defined.
module btb_ctrl #(
   parameter int NUM_SETS = 16,
   parameter int SET_W    = 4,
   parameter int STAT_W   = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              resolve_valid,
   input  logic              load_btb,
   input  logic              resolve_hit,
   input  logic              mispredict,
   input  logic              pipe_stall,
   input  logic              if_lookup,
   input  logic              if_hit,
   input  logic              flush_req,
   output logic              load_tag,
   output logic              load_target,
   output logic              load_valid,
   output logic              load_lru,
   output logic              lru_store,
   output logic              load_bht,
   output logic              clear_bht,
   output logic              clear_valid,
   output logic              clear_target_holder,
   output logic [SET_W-1:0]  flush_set,
   output logic              flush_active,
   output logic              busy,
   output logic [STAT_W-1:0] stat_lookups,
   output logic [STAT_W-1:0] stat_hits,
   output logic [STAT_W-1:0] stat_mispredicts
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      CLEAR = 2'd2,
      FLUSH = 2'd3
   } state_t;

   localparam logic [SET_W-1:0] LAST_SET = SET_W'(NUM_SETS - 1);

   state_t           state_r;
   state_t           state_next;
   logic [SET_W-1:0] flush_cnt_r;
   logic             accept;
   logic             alloc;
   logic             touch;

   assign flush_active = (state_r == FLUSH);
   assign accept       = resolve_valid & load_btb & ~pipe_stall & ~flush_active;
   assign alloc        = accept & ~resolve_hit;
   assign touch        = if_lookup & if_hit & ~pipe_stall;
   assign busy         = (state_r != IDLE);
   assign flush_set    = flush_cnt_r;
   // BHT update is combinational so the resolve stage sees it in its own cycle.
   assign load_bht     = accept;

   // State register; reset aborts any write or flush in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_next;
      end
   end

   // Flush set counter: walks every set during FLUSH and rests at 0 otherwise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flush_cnt_r <= {SET_W{1'b0}};
      end else if (state_r == FLUSH && flush_cnt_r != LAST_SET) begin
         flush_cnt_r <= flush_cnt_r + {{(SET_W-1){1'b0}}, 1'b1};
      end else begin
         flush_cnt_r <= {SET_W{1'b0}};
      end
   end

   // Next-state logic; a flush request outranks a pending allocate.
   always_comb begin
      state_next = state_r;
      case (state_r)
         IDLE: begin
            if (flush_req)  state_next = FLUSH;
            else if (alloc) state_next = WRITE;
            else            state_next = IDLE;
         end
         WRITE: begin
            if (flush_req)  state_next = FLUSH;
            else if (alloc) state_next = WRITE;
            else            state_next = CLEAR;
         end
         CLEAR: begin
            if (flush_req)  state_next = FLUSH;
            else if (alloc) state_next = WRITE;
            else            state_next = IDLE;
         end
         FLUSH: begin
            if (flush_cnt_r == LAST_SET) state_next = IDLE;
            else                         state_next = FLUSH;
         end
         default: state_next = IDLE;
      endcase
   end

   // Write/clear strobes decoded from the current state.
   always_comb begin
      load_tag            = 1'b0;
      load_target         = 1'b0;
      load_valid          = 1'b0;
      load_lru            = 1'b0;
      lru_store           = 1'b0;
      clear_bht           = 1'b0;
      clear_valid         = 1'b0;
      clear_target_holder = 1'b0;
      case (state_r)
         IDLE: begin
            load_lru = touch;
         end
         WRITE: begin
            // Allocate owns the LRU port here, so hit touches are dropped.
            load_tag    = 1'b1;
            load_target = 1'b1;
            load_valid  = 1'b1;
            load_lru    = 1'b1;
            lru_store   = 1'b1;
         end
         CLEAR: begin
            clear_target_holder = 1'b1;
            load_lru            = touch;
         end
         FLUSH: begin
            clear_valid         = 1'b1;
            clear_bht           = (flush_cnt_r == {SET_W{1'b0}});
            clear_target_holder = (flush_cnt_r == LAST_SET);
         end
         default: begin
            load_lru = 1'b0;
         end
      endcase
   end

`ifdef BTB_STATS_EN
   logic flush_entry;
   assign flush_entry = (state_r != FLUSH) && (state_next == FLUSH);

   // Saturating statistics counters, zeroed when a flush begins.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_lookups     <= {STAT_W{1'b0}};
         stat_hits        <= {STAT_W{1'b0}};
         stat_mispredicts <= {STAT_W{1'b0}};
      end else if (flush_entry) begin
         stat_lookups     <= {STAT_W{1'b0}};
         stat_hits        <= {STAT_W{1'b0}};
         stat_mispredicts <= {STAT_W{1'b0}};
      end else begin
         if (if_lookup && !pipe_stall && stat_lookups != {STAT_W{1'b1}})
            stat_lookups <= stat_lookups + {{(STAT_W-1){1'b0}}, 1'b1};
         else
            stat_lookups <= stat_lookups;
         if (if_lookup && !pipe_stall && if_hit && stat_hits != {STAT_W{1'b1}})
            stat_hits <= stat_hits + {{(STAT_W-1){1'b0}}, 1'b1};
         else
            stat_hits <= stat_hits;
         if (accept && mispredict && stat_mispredicts != {STAT_W{1'b1}})
            stat_mispredicts <= stat_mispredicts + {{(STAT_W-1){1'b0}}, 1'b1};
         else
            stat_mispredicts <= stat_mispredicts;
      end
   end
`else
   logic unused_stats;
   assign unused_stats     = &{1'b0, mispredict};
   assign stat_lookups     = {STAT_W{1'b0}};
   assign stat_hits        = {STAT_W{1'b0}};
   assign stat_mispredicts = {STAT_W{1'b0}};
`endif

endmodule

// File: tb/tb_btb_ctrl.sv
// Directed bench for btb_ctrl. Each step drives one cycle of inputs, pushes the
// expected strobe vector onto a scoreboard queue, then pops and compares it
// against the DUT outputs in the low clock phase.
module tb_btb_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        resolve_valid, load_btb, resolve_hit, mispredict, pipe_stall;
   logic        if_lookup, if_hit, flush_req;
   logic        load_tag, load_target, load_valid, load_lru, lru_store, load_bht;
   logic        clear_bht, clear_valid, clear_target_holder, flush_active, busy;
   logic [3:0]  flush_set;
   logic [15:0] stat_lookups, stat_hits, stat_mispredicts;

   int compared   = 0;
   int mismatched = 0;
   logic [14:0] exp_q[$];

   // inputs: {resolve_valid, load_btb, resolve_hit, mispredict, pipe_stall, if_lookup, if_hit, flush_req}
   localparam logic [7:0] I_NONE   = 8'b0000_0000;
   localparam logic [7:0] I_MISS   = 8'b1100_0000;
   localparam logic [7:0] I_HIT    = 8'b1110_0000;
   localparam logic [7:0] I_MPMISS = 8'b1101_0000;
   localparam logic [7:0] I_STALLM = 8'b1100_1000;
   localparam logic [7:0] I_FLUSH  = 8'b0000_0001;
   localparam logic [7:0] I_MISSFL = 8'b1100_0001;
   localparam logic [7:0] I_LOOK   = 8'b0000_0110;
   localparam logic [7:0] I_LOOKST = 8'b0000_1110;
   localparam logic [7:0] I_MISSLK = 8'b1100_0110;
   localparam logic [7:0] I_LOOKNH = 8'b0000_0100;

   // outputs: {tag, target, valid, lru, lru_store, bht, clear_bht, clear_valid, clear_holder, flush_active, busy, flush_set[3:0]}
   localparam logic [14:0] E_IDLE    = 15'h0000;
   localparam logic [14:0] E_BHT     = 15'h0200;
   localparam logic [14:0] E_WRITE   = 15'h7C10;
   localparam logic [14:0] E_WRBHT   = 15'h7E10;
   localparam logic [14:0] E_CLEAR   = 15'h0050;
   localparam logic [14:0] E_TOUCH   = 15'h0800;
   localparam logic [14:0] E_BHTTCH  = 15'h0A00;

   btb_ctrl dut (
      .clk(clk), .rst_n(rst_n),
      .resolve_valid(resolve_valid), .load_btb(load_btb), .resolve_hit(resolve_hit),
      .mispredict(mispredict), .pipe_stall(pipe_stall), .if_lookup(if_lookup),
      .if_hit(if_hit), .flush_req(flush_req),
      .load_tag(load_tag), .load_target(load_target), .load_valid(load_valid),
      .load_lru(load_lru), .lru_store(lru_store), .load_bht(load_bht),
      .clear_bht(clear_bht), .clear_valid(clear_valid),
      .clear_target_holder(clear_target_holder), .flush_set(flush_set),
      .flush_active(flush_active), .busy(busy),
      .stat_lookups(stat_lookups), .stat_hits(stat_hits), .stat_mispredicts(stat_mispredicts)
   );

   always #5 clk = ~clk;

   function automatic logic [14:0] e_flush(input int k);
      logic [14:0] e;
      e = 15'h00B0 | 15'(k);
      if (k == 0)  e = e | 15'h0100;
      if (k == 15) e = e | 15'h0040;
      return e;
   endfunction

   function automatic logic [14:0] observed();
      return {load_tag, load_target, load_valid, load_lru, lru_store, load_bht,
              clear_bht, clear_valid, clear_target_holder, flush_active, busy, flush_set};
   endfunction

   task automatic drive(input logic [7:0] ins);
      {resolve_valid, load_btb, resolve_hit, mispredict, pipe_stall, if_lookup, if_hit, flush_req} = ins;
   endtask

   task automatic check_now(input string tag);
      logic [14:0] e;
      logic [14:0] got;
      e   = exp_q.pop_front();
      got = observed();
      compared++;
      assert (got === e) else begin
         mismatched++;
         $error("FAIL %s observed=%h expected=%h", tag, got, e);
      end
   endtask

   // One cycle: drive at negedge, check mid-low phase, then cross the posedge.
   task automatic step(input string tag, input logic [7:0] ins, input logic [14:0] e);
      @(negedge clk);
      drive(ins);
      exp_q.push_back(e);
      #1;
      check_now(tag);
   endtask

   task automatic check_stats(input string tag, input logic [15:0] el,
                              input logic [15:0] eh, input logic [15:0] em);
      compared++;
      assert (stat_lookups === el && stat_hits === eh && stat_mispredicts === em) else begin
         mismatched++;
         $error("FAIL %s observed=%h/%h/%h expected=%h/%h/%h", tag,
                stat_lookups, stat_hits, stat_mispredicts, el, eh, em);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      drive(I_NONE);
      #1;
      exp_q.push_back(E_IDLE);
      check_now("reset_outputs");
      check_stats("reset_stats", 16'h0000, 16'h0000, 16'h0000);
      @(negedge clk);
      rst_n = 1'b1;

      // 1: single allocate miss
      step("t1_bht",   I_MISS, E_BHT);
      step("t1_write", I_NONE, E_WRITE);
      step("t1_clear", I_NONE, E_CLEAR);
      step("t1_idle",  I_NONE, E_IDLE);

      // hit accept: BHT only; stalled accept: nothing
      step("hit_bht",    I_HIT,    E_BHT);
      step("hit_idle",   I_NONE,   E_IDLE);
      step("stall_none", I_STALLM, E_IDLE);
      step("stall_idle", I_NONE,   E_IDLE);

      // 2: back-to-back misses
      step("t2_bht0",   I_MISS, E_BHT);
      step("t2_write1", I_MISS, E_WRBHT);
      step("t2_write2", I_NONE, E_WRITE);
      step("t2_clear",  I_NONE, E_CLEAR);
      step("t2_idle",   I_NONE, E_IDLE);

      // 3: flush beats accept; accept and flush_req ignored during FLUSH
      step("t3_entry", I_MISSFL, E_BHT);
      for (int k = 0; k < 16; k++) step($sformatf("t3_flush%0d", k), I_MISSFL, e_flush(k));
      step("t3_idle", I_NONE, E_IDLE);

      // 4: flush requested during WRITE, then reset mid-flush
      step("t4_bht",   I_MISS,  E_BHT);
      step("t4_write", I_FLUSH, E_WRITE);
      for (int k = 0; k < 7; k++) step($sformatf("t4_flush%0d", k), I_NONE, e_flush(k));
      step("t4_flush7", I_NONE, e_flush(7));
      #1;
      rst_n = 1'b0;
      #1;
      exp_q.push_back(E_IDLE);
      check_now("t4_reset");
      @(negedge clk);
      rst_n = 1'b1;
      step("t4_idle", I_NONE, E_IDLE);

      // 5: LRU touch in IDLE, blocked by stall, dropped during WRITE
      step("t5_touch",  I_LOOK,   E_TOUCH);
      step("t5_stall",  I_LOOKST, E_IDLE);
      step("t5_bhttch", I_MISSLK, E_BHTTCH);
      step("t5_write",  I_LOOK,   E_WRITE);
      step("t5_clear",  I_NONE,   E_CLEAR);
      step("t5_idle",   I_NONE,   E_IDLE);

      // 6: statistics
      step("t6_bht",   I_MPMISS, E_BHT);
      step("t6_write", I_NONE,   E_WRITE);
      step("t6_clear", I_NONE,   E_CLEAR);
      step("t6_idle",  I_NONE,   E_IDLE);
`ifdef BTB_STATS_EN
      check_stats("t6_counts", 16'd3, 16'd3, 16'd1);
      for (int n = 0; n < 65537; n++) begin
         @(negedge clk);
         drive(I_LOOKNH);
      end
      @(negedge clk);
      drive(I_NONE);
      #1;
      check_stats("t6_saturate", 16'hFFFF, 16'd3, 16'd1);
      step("t6_fl_entry", I_FLUSH, E_IDLE);
      @(negedge clk);
      drive(I_NONE);
      #1;
      check_stats("t6_flush_clr", 16'h0000, 16'h0000, 16'h0000);
      exp_q.push_back(e_flush(0));
      check_now("t6_flush0");
      for (int k = 1; k < 16; k++) step($sformatf("t6_flush%0d", k), I_NONE, e_flush(k));
`else
      check_stats("t6_tied0", 16'h0000, 16'h0000, 16'h0000);
`endif
      step("final_idle", I_NONE, E_IDLE);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
